// File: rtl/npu_out_collector_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the NPU output collector.
package npu_out_collector_pkg;

    localparam int CH         = 8;
    localparam int DW         = 8;
    localparam int PACK       = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    localparam int WORD_W  = PACK * DW;
    localparam int CNT_W   = $clog2(PACK);
    localparam int CH_W    = 3;
    localparam int BYTES_W = 3;

    // Entry layout: data in the top WORD_W bits, then source lane, then byte count.
    typedef struct packed {
        logic [WORD_W-1:0]  data;
        logic [CH_W-1:0]    ch;
        logic [BYTES_W-1:0] bytes;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] place_byte(input logic [DW-1:0] b,
                                                     input logic [CNT_W-1:0] slot);
        place_byte = WORD_W'(b) << (DW * (PACK - 1 - int'(slot)));
    endfunction

endpackage

// File: rtl/npu_out_collector_if.sv
// Lane byte stream in, packed-word valid/ready stream out.
interface npu_out_collector_if;
    import npu_out_collector_pkg::*;

    logic [CH*DW-1:0]   npu_out;
    logic [CH-1:0]      npu_out_en;
    logic               flush;
    logic [WORD_W-1:0]  o_data;
    logic [CH_W-1:0]    o_ch;
    logic [BYTES_W-1:0] o_bytes;
    logic               o_valid;
    logic               o_ready;

    modport master (
        output npu_out, npu_out_en, flush, o_ready,
        input  o_data, o_ch, o_bytes, o_valid
    );

    modport slave (
        input  npu_out, npu_out_en, flush, o_ready,
        output o_data, o_ch, o_bytes, o_valid
    );

endinterface

// File: rtl/npu_out_fifo.sv
// Synchronous show-ahead FIFO: head_data reflects the oldest entry whenever empty is low.
module npu_out_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all readers see the pre-edge value.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; empty gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/npu_out_collector.sv
// Packs per-lane NPU result bytes into words, arbitrates them round-robin into a FIFO, supports flush.
module npu_out_collector
    import npu_out_collector_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    npu_out_collector_if.slave bus,
    output logic               flush_done,
    output logic               busy,
    output logic [CH-1:0]      overflow
);

    state_e             state;
    state_e             state_nx;
    logic [CH-1:0]      pend_valid;
    logic [CH-1:0]      cnt_nz;
    logic [CH-1:0]      grant;
    logic [WORD_W-1:0]  pend_data  [CH];
    logic [BYTES_W-1:0] pend_bytes [CH];
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_any;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    entry_t             push_entry;
    entry_t             head_entry;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic [DW-1:0]      lane_byte;
        logic               lane_en;
        logic               accept;
        logic               complete;
        logic               slot_free;
        logic               promote;
        logic [CNT_W-1:0]   cnt;
        logic [WORD_W-1:0]  shreg;
        logic [WORD_W-1:0]  merged;
        logic               pv;
        logic [WORD_W-1:0]  pd;
        logic [BYTES_W-1:0] pb;
        logic               ovf;

        // Lane 0 sits in the MSBs of both the byte bus and the enable vector.
        assign lane_byte = bus.npu_out[(CH-c)*DW-1 -: DW];
        assign lane_en   = bus.npu_out_en[CH-1-c];
        assign accept    = lane_en && (state == ST_IDLE);
        assign complete  = accept && (cnt == CNT_W'(PACK-1));
        assign slot_free = !pv || grant[c];
        assign promote   = (state == ST_FLUSH) && (cnt != '0) && slot_free;
        assign merged    = shreg | place_byte(lane_byte, cnt);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                shreg <= '0;
                pv    <= 1'b0;
                pd    <= '0;
                pb    <= '0;
                ovf   <= 1'b0;
            end else begin
                // Shift register is kept zero past the fill point so flush words come out padded.
                if (accept) begin
                    cnt   <= complete ? '0 : cnt + 1'b1;
                    shreg <= complete ? '0 : merged;
                end else if (promote) begin
                    cnt   <= '0;
                    shreg <= '0;
                end

                if (complete && slot_free) begin
                    pv <= 1'b1;
                    pd <= merged;
                    pb <= BYTES_W'(PACK);
                end else if (promote) begin
                    pv <= 1'b1;
                    pd <= shreg;
                    pb <= BYTES_W'(cnt);
                end else if (grant[c]) begin
                    pv <= 1'b0;
                end

                if ((complete && !slot_free) || (lane_en && state != ST_IDLE))
                    ovf <= 1'b1;
            end
        end

        assign pend_valid[c]     = pv;
        assign pend_data[c]      = pd;
        assign pend_bytes[c]     = pb;
        assign cnt_nz[c]         = (cnt != '0);
        assign overflow[CH-1-c]  = ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_nx   = state;
        flush_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.flush) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_nz == '0 && pend_valid == '0) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    flush_done = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Round-robin search starting at rr_ptr; no grant at all while the FIFO is full.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!fifo_full) begin
            for (int i = 0; i < CH; i++) begin
                if (!grant_any && pend_valid[(int'(rr_ptr) + i) % CH]) begin
                    grant_any = 1'b1;
                    grant_idx = CH_W'((int'(rr_ptr) + i) % CH);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)          rr_ptr <= '0;
        else if (grant_any) rr_ptr <= CH_W'((int'(grant_idx) + 1) % CH);
    end

    always_comb begin
        push_entry.data  = pend_data[grant_idx];
        push_entry.ch    = grant_idx;
        push_entry.bytes = pend_bytes[grant_idx];
    end

    npu_out_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_any),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.o_valid = !fifo_empty;
    assign fifo_pop    = bus.o_valid && bus.o_ready;
    assign bus.o_data  = fifo_empty ? '0 : head_entry.data;
    assign bus.o_ch    = fifo_empty ? '0 : head_entry.ch;
    assign bus.o_bytes = fifo_empty ? '0 : head_entry.bytes;

endmodule

// File: doc/npu_out_collector.md
Name: npu_out_collector

Overview:
- Receiver on the NPU result interface: accepts the 8-lane byte stream (out/out_en) produced by the arithmetic part.
- Packs each lane's bytes into 32-bit words and arbitrates completed words round-robin into a show-ahead FIFO.
- Presents the FIFO to the host/DMA side over a valid/ready port.
- Supports an explicit flush that emits zero-padded partial words, then signals completion.

Parameters:
- CH, 8, number of output lanes (matches NPU out_en width)
- DW, 8, bits per lane byte
- PACK, 4, bytes per packed word
- FIFO_DEPTH, 16, entries in the output FIFO (power of two)
- FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- npu_out  in  CH*DW  lane bytes; lane 0 in bits [CH*DW-1 -: DW], lane CH-1 in LSBs
- npu_out_en  in  CH  per-lane byte valid; bit 7 = lane 0, bit 0 = lane 7
- flush  in  1  single-cycle flush request
- o_data  out  PACK*DW  packed word; first-received byte in MSBs
- o_ch  out  3  source lane of o_data
- o_bytes  out  3  valid bytes in o_data, 1..4
- o_valid  out  1  FIFO head valid
- o_ready  in  1  host accepts head when o_valid&&o_ready
- flush_done  out  1  one-cycle pulse at end of flush
- busy  out  1  high while FSM is not IDLE
- overflow  out  CH  sticky per-lane drop flag; same lane order as npu_out_en

Behaviour:
- Reset (synchronous): all outputs 0. Byte counters, pending slots, round-robin pointer and FIFO pointers are cleared, and the FSM goes to IDLE. Partial data is discarded, including reset mid-flush.
- Packer, one per lane:
  - Each lane has a 2-bit count and a PACK*DW shift register.
  - A sampled npu_out_en[c] stores the byte at slot count (slot 0 = MSBs) and increments count.
  - On the 4th byte the word moves to pending[c] with bytes=4, and count returns to 0.
- Pending slot: one word per lane.
  - If a word completes while pending[c] is set and is not granted that same cycle, the new word is dropped and overflow[c] is set.
  - If the word completes in the same cycle its lane is granted, the new word takes the slot and no overflow is flagged.
- Arbiter:
  - When the FIFO is not full, grant the first pending lane at or after rr_ptr, wrapping modulo CH.
  - Push {word, ch, bytes} into the FIFO and clear pending.
  - Set rr_ptr = grant+1. At most one push per cycle.
  - When the FIFO is full, there is no push; pop-same-cycle bypass is not provided.
- Latency: 4th byte sampled at edge k -> pending after k -> FIFO write at k+1 -> o_valid after k+1 (2 cycles).
- FIFO:
  - Show-ahead: o_data, o_ch and o_bytes are valid whenever o_valid is high.
  - Pop on o_valid&&o_ready.
  - A simultaneous push and pop is allowed when the FIFO is not full. Head ordering is preserved.
- FSM states:
  - IDLE: normal operation. flush=1 -> FLUSH.
  - FLUSH:
    - Lanes with count>0 are promoted to pending when the slot is free (or granted that cycle).
    - A promoted word is zero-padded, with bytes=count.
    - npu_out_en bytes arriving in FLUSH or DRAIN are dropped and set overflow[c].
    - When all counts are 0 and all pending are 0 -> DRAIN.
  - DRAIN: when the FIFO is empty, pulse flush_done for one cycle -> IDLE.
- Flush coincident with npu_out_en[c] in IDLE: the byte is accepted first, then flush applies to the next cycle. If that byte completes a word, it is a normal 4-byte word.
- flush while busy: ignored.
- Overflow bits clear only on reset.

Decomposition:
- Shared include npu_params.vh holds:
  - constants CH, DW, PACK
  - FIFO entry field offsets (data, ch, bytes; entry width PACK*DW+6)
  - FSM state encodings (IDLE=0, FLUSH=1, DRAIN=2)
- Sub-module npu_out_fifo: synchronous show-ahead FIFO, parameterised by width/depth, with full/empty flags.
- Packers and arbiter stay in generate loops in the top.

Test Plan:
- Lane 0 bytes 0x11,0x22,0x33,0x44 on consecutive cycles, o_ready=1 -> o_valid 2 cycles after the 4th byte; o_data=0x11223344, o_ch=0, o_bytes=4.
- All 8 lanes complete words on the same edge, o_ready=1 -> 8 words over 8 consecutive cycles in order ch 0,1,...,7. A second burst starts at rr_ptr=0 again.
- o_ready=0 and lane 3 streams 80 bytes (20 words) -> FIFO holds 16 entries. The 17th word sits in pending. The 18th word drops with overflow[3] (bit 4 of overflow)=1. After draining, exactly 17 words are received, in order.
- Lane 5 gets 0xAA,0xBB then flush -> busy=1; one word with o_data=0xAABB0000, o_ch=5, o_bytes=2. flush_done pulses once after it is popped, then busy=0.
- Byte on lane 2 during FLUSH -> byte discarded, overflow[2] (bit 5) set. Flush still completes.
- Reset asserted mid-flush with 3 partial lanes and 5 FIFO entries -> next cycle o_valid=0, busy=0, overflow=0. A new 4-byte sequence on lane 1 produces o_bytes=4 with no stale data.
